// File: rtl/tpu_host_seq.sv
// Bus-initiator sequencer for the 8x8 systolic TPU: streams A/B/C operands in, fires matmul,
// waits the fixed run length, streams C out. Define TPU_HOST_CLEAR_C_EN to zero C instead of loading it.
module tpu_host_seq #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64,
    parameter int MM_WAIT = 4 * DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_wdata,
    input  logic [DATAW-1:0] tpu_rdata
);

    localparam int RW     = $clog2(DIM);
    localparam int WW     = $clog2(MM_WAIT + 1);
    localparam int HALVES = (DIM * BITS_C) / DATAW;

    localparam logic [ADDRW-1:0] A_BASE     = ADDRW'('h100);
    localparam logic [ADDRW-1:0] B_BASE     = ADDRW'('h200);
    localparam logic [ADDRW-1:0] C_BASE     = ADDRW'('h300);
    localparam logic [ADDRW-1:0] MM_ADDR    = ADDRW'('h400);
    localparam logic [ADDRW-1:0] ROW_STRIDE = ADDRW'((DIM * BITS_AB) / 8);
    localparam logic [ADDRW-1:0] WORD_BYTES = ADDRW'(DATAW / 8);
    localparam logic [ADDRW-1:0] C_STRIDE   = ADDRW'(HALVES * (DATAW / 8));

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_LOAD_C = 3'd3;
    localparam logic [2:0] S_MATMUL = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_READ_C = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic          half_q, half_d;
    logic [WW-1:0] wait_q, wait_d;

    logic             row_last;
    logic             c_last;
    logic [ADDRW-1:0] a_addr;
    logic [ADDRW-1:0] b_addr;
    logic [ADDRW-1:0] c_addr;

    assign row_last = (row_q == RW'(DIM - 1));
    assign c_last   = row_last && (half_q == 1'(HALVES - 1));
    assign a_addr   = A_BASE + ADDRW'(row_q) * ROW_STRIDE;
    assign b_addr   = B_BASE + ADDRW'(row_q) * ROW_STRIDE;
    assign c_addr   = C_BASE + ADDRW'(row_q) * C_STRIDE + (half_q ? WORD_BYTES : '0);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        half_d    = half_q;
        wait_d    = wait_q;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        tpu_r_w   = 1'b0;
        tpu_addr  = '0;
        tpu_wdata = '0;

        case (state_q)
            S_IDLE: begin
                row_d  = '0;
                half_d = 1'b0;
                wait_d = '0;
                if (start) begin
                    state_d = S_LOAD_A;
                end
            end

            S_LOAD_A, S_LOAD_B: begin
                in_ready = 1'b1;
                // Bus stays idle on bubbles: the TPU's B shifter moves on any B-address cycle.
                if (in_valid) begin
                    tpu_r_w   = 1'b1;
                    tpu_addr  = (state_q == S_LOAD_A) ? a_addr : b_addr;
                    tpu_wdata = in_data;
                    row_d     = row_q + RW'(1);
                    if (row_last) begin
                        row_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_LOAD_C;
                    end
                end
            end

            S_LOAD_C: begin
`ifdef TPU_HOST_CLEAR_C_EN
                tpu_r_w   = 1'b1;
                tpu_addr  = c_addr;
                tpu_wdata = '0;
                half_d    = ~half_q;
                if (half_q) begin
                    row_d = row_q + RW'(1);
                end
                if (c_last) begin
                    row_d   = '0;
                    half_d  = 1'b0;
                    state_d = S_MATMUL;
                end
`else
                in_ready = 1'b1;
                if (in_valid) begin
                    tpu_r_w   = 1'b1;
                    tpu_addr  = c_addr;
                    tpu_wdata = in_data;
                    half_d    = ~half_q;
                    if (half_q) begin
                        row_d = row_q + RW'(1);
                    end
                    if (c_last) begin
                        row_d   = '0;
                        half_d  = 1'b0;
                        state_d = S_MATMUL;
                    end
                end
`endif
            end

            S_MATMUL: begin
                tpu_r_w  = 1'b1;
                tpu_addr = MM_ADDR;
                wait_d   = WW'(MM_WAIT);
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                wait_d = wait_q - WW'(1);
                if (wait_q == WW'(1)) begin
                    state_d = S_READ_C;
                end
            end

            S_READ_C: begin
                out_valid = 1'b1;
                tpu_addr  = c_addr;
                out_data  = tpu_rdata;
                if (out_ready) begin
                    half_d = ~half_q;
                    if (half_q) begin
                        row_d = row_q + RW'(1);
                    end
                    if (c_last) begin
                        row_d   = '0;
                        half_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            half_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            half_q  <= half_d;
            wait_q  <= wait_d;
        end
    end

endmodule
